matrix_calc_core: RTL and testbench
===================================

# matrix_calc_core

Computation engine that answers the operation controller's `calc_start` request. It latches the operation code and operand dimensions, reads matrix A and B elements from matrix storage through a 1-cycle-latency read port, and computes C = A + B or C = A × B. It writes each result element to the result store, then pulses `calc_done`. It is the responder side of the controller→core start/done handshake.

## Interface
- `MAX_DIM`, 5: maximum rows/cols of any matrix; element address = row*MAX_DIM + col
- `DATA_W`, 8: unsigned operand element width
- `ACC_W`, 20: result/accumulator width; must be ≥ 2*DATA_W+3
- `ADDR_W`, 5: element address width, ≥ clog2(MAX_DIM*MAX_DIM)

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `calc_start`  in  1  start request, level-held by the controller; the core acts on its rising edge only
- `calc_abort`  in  1  synchronous abort; returns to IDLE with no done pulse
- `op_code`  in  1  0 = add, 1 = multiply
- `matA_row`, `matA_col`, `matB_row`, `matB_col`  in  8 each  operand dimensions
- `rd_sel`  out  1  0 = read matrix A, 1 = read matrix B
- `rd_addr`  out  ADDR_W  read element address
- `rd_data`  in  DATA_W  read data, valid the cycle after the address
- `wr_en`  out  1  result write strobe
- `wr_addr`  out  ADDR_W  result element address
- `wr_data`  out  ACC_W  result element value
- `res_row`, `res_col`  out  8 each  result dimensions, latched at start
- `busy`  out  1  high from the first RD_A cycle through DONE
- `calc_done`  out  1  one-cycle completion pulse
- `calc_err`  out  1  valid with `calc_done`; high if the dimensions were rejected

## Operation
- Start edge: `calc_start`=1 while its registered previous value is 0, in IDLE. A held-high `calc_start` never retriggers. Start edges outside IDLE are ignored.
- On the start edge, latch `op_code` and the dimensions, and set R, C, K:
  - add: R=A_row, C=A_col, K=1
  - mul: R=A_row, C=B_col, K=A_col
- Rejection: any used dimension is 0 or >MAX_DIM; for add, A≠B in either dimension; for mul, A_col≠B_row. A rejected start goes straight to DONE with `calc_err`=1 and performs no reads or writes.
- States:
  - IDLE
  - RD_A: `rd_sel`=0, `rd_addr`=i*MAX_DIM+k for mul, i*MAX_DIM+j for add
  - RD_B: `rd_sel`=1, `rd_addr`=k*MAX_DIM+j for mul, i*MAX_DIM+j for add; capture `rd_data` into a_reg
  - ACC: acc += a_reg+rd_data for add, a_reg*rd_data for mul; k++. Go to WR if k=K-1, else RD_A.
  - WR: `wr_en`=1, `wr_addr`=i*MAX_DIM+j, `wr_data`=acc; clear acc and k; advance j, then i (row-major)
  - DONE: after the last element's WR go to DONE; `calc_done`=1 for one cycle, then IDLE
- Arithmetic is unsigned and zero-extended to ACC_W, with wrap modulo 2^ACC_W. Overflow cannot occur within the parameter constraint.
- `calc_abort` in any non-IDLE state forces IDLE next cycle with no WR and no `calc_done`. Abort takes priority over all other transitions.
- Outputs are decoded from registered state and counters only; no input→output combinational path.

## Timing
- Reset values: all outputs 0, state IDLE, acc 0, counters 0, previous-start register 0.
- Cycle 0 is the cycle in which the start edge is sampled. The first RD_A is cycle 1.
- Each element takes 3K+1 cycles. `calc_done` is high in cycle 1+R*C*(3K+1).
- A rejected start puts `calc_done` in cycle 1.
- `rst` mid-operation clears everything immediately; no further writes occur.
- `busy` falls in the cycle after DONE.

## Structure
- Shared package `matrix_pkg`:
  - state enum
  - op code constants OP_ADD=0, OP_MUL=1
  - MAX_DIM
  - address helper function row*MAX_DIM+col
- One natural sub-module, `mac_unit`: a combinational add/multiply selector feeding the acc register. Everything else stays in one FSM module.

## Test plan
- 2×2 add, A=[1,2;3,4], B=[5,6;7,8], start edge at cycle 0 → writes 6,8,10,12 at addresses 0,1,5,6; `calc_done` at cycle 17; `calc_err`=0.
- 2×3 × 3×2 mul, A=[1,2,3;4,5,6], B=[7,8;9,10;11,12] → writes 58,64,139,154 at addresses 0,1,5,6; `calc_done` at cycle 41.
- Mul with A 2×3, B 2×2 → `calc_done`+`calc_err` at cycle 1; `wr_en` never asserted.
- `calc_start` held high for 200 cycles after completion → exactly one `calc_done`; drop to 0 then raise again → second run starts.
- 5×5 mul with all elements 255 → every `wr_data`=325125 and no wrap; `calc_done` at cycle 1+25*16=401.
- `calc_abort` at cycle 10 of a 2×2 add, or `rst` at cycle 10 → no further `wr_en`, no `calc_done`; IDLE next cycle; `busy`=0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix calculation core.
// Element addresses are row-major with a fixed stride of MAX_DIM.
package matrix_pkg;

   localparam int MAX_DIM = 5;
   localparam int DATA_W  = 8;
   localparam int ACC_W   = 20;
   localparam int ADDR_W  = 5;
   localparam int IDX_W   = 3;
   localparam int DIM_W   = 8;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_MUL = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_A,
      S_RD_B,
      S_ACC,
      S_WR,
      S_DONE
   } state_e;

   function automatic logic [ADDR_W-1:0] elem_addr(
      input logic [IDX_W-1:0] row,
      input logic [IDX_W-1:0] col
   );
      logic [ADDR_W-1:0] r;
      logic [ADDR_W-1:0] c;
      r = ADDR_W'(row);
      c = ADDR_W'(col);
      return r * ADDR_W'(MAX_DIM) + c;
   endfunction

   function automatic logic dim_bad(input logic [DIM_W-1:0] d);
      return (d == '0) || (d > DIM_W'(MAX_DIM));
   endfunction

endpackage

// File: rtl/matrix_calc_core_mac_unit.sv
// Combinational accumulate step: acc plus either a+b or a*b.
// Terms are zero-extended so the sum wraps modulo 2^ACC_W.
module mac_unit
   import matrix_pkg::*;
#(
   parameter int D_W = DATA_W,
   parameter int A_W = ACC_W
) (
   input  logic           op,
   input  logic [D_W-1:0] a,
   input  logic [D_W-1:0] b,
   input  logic [A_W-1:0] acc_in,
   output logic [A_W-1:0] acc_out
);

   logic [D_W:0]     sum;
   logic [2*D_W-1:0] prod;
   logic [A_W-1:0]   term;

   always_comb begin
      sum  = {1'b0, a} + {1'b0, b};
      prod = a * b;
      if (op == OP_ADD) begin
         term = A_W'(sum);
      end else begin
         term = A_W'(prod);
      end
      acc_out = acc_in + term;
   end

endmodule

// File: rtl/matrix_calc_core.sv
// Matrix add/multiply engine: reads A and B through a 1-cycle read port,
// accumulates each result element and writes it to the result store.
module matrix_calc_core
   import matrix_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              calc_start,
   input  logic              calc_abort,
   input  logic              op_code,
   input  logic [DIM_W-1:0]  matA_row,
   input  logic [DIM_W-1:0]  matA_col,
   input  logic [DIM_W-1:0]  matB_row,
   input  logic [DIM_W-1:0]  matB_col,
   output logic              rd_sel,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ACC_W-1:0]  wr_data,
   output logic [DIM_W-1:0]  res_row,
   output logic [DIM_W-1:0]  res_col,
   output logic              busy,
   output logic              calc_done,
   output logic              calc_err
);

   state_e             state_q, state_d;
   logic               start_q, start_d;
   logic               op_q, op_d;
   logic               err_q, err_d;
   logic [IDX_W-1:0]   r_q, r_d;
   logic [IDX_W-1:0]   c_q, c_d;
   logic [IDX_W-1:0]   kmax_q, kmax_d;
   logic [IDX_W-1:0]   i_q, i_d;
   logic [IDX_W-1:0]   j_q, j_d;
   logic [IDX_W-1:0]   k_q, k_d;
   logic [DATA_W-1:0]  a_reg_q, a_reg_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [DIM_W-1:0]   res_row_q, res_row_d;
   logic [DIM_W-1:0]   res_col_q, res_col_d;
   logic [ACC_W-1:0]   mac_out;
   logic               start_edge;
   logic               reject;

   mac_unit u_mac (
      .op      (op_q),
      .a       (a_reg_q),
      .b       (rd_data),
      .acc_in  (acc_q),
      .acc_out (mac_out)
   );

   assign start_edge = calc_start && !start_q && (state_q == S_IDLE);

   always_comb begin
      reject = 1'b0;
      if (op_code == OP_MUL) begin
         reject = dim_bad(matA_row) || dim_bad(matA_col) ||
                  dim_bad(matB_row) || dim_bad(matB_col) ||
                  (matA_col != matB_row);
      end else begin
         reject = dim_bad(matA_row) || dim_bad(matA_col) ||
                  (matA_row != matB_row) ||
                  (matA_col != matB_col);
      end
   end

   always_comb begin
      state_d   = state_q;
      start_d   = calc_start;
      op_d      = op_q;
      err_d     = err_q;
      r_d       = r_q;
      c_d       = c_q;
      kmax_d    = kmax_q;
      i_d       = i_q;
      j_d       = j_q;
      k_d       = k_q;
      a_reg_d   = a_reg_q;
      acc_d     = acc_q;
      res_row_d = res_row_q;
      res_col_d = res_col_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_edge) begin
               op_d      = op_code;
               err_d     = reject;
               r_d       = matA_row[IDX_W-1:0];
               res_row_d = matA_row;
               i_d       = '0;
               j_d       = '0;
               k_d       = '0;
               acc_d     = '0;
               if (op_code == OP_MUL) begin
                  c_d       = matB_col[IDX_W-1:0];
                  kmax_d    = matA_col[IDX_W-1:0];
                  res_col_d = matB_col;
               end else begin
                  c_d       = matA_col[IDX_W-1:0];
                  kmax_d    = IDX_W'(1);
                  res_col_d = matA_col;
               end
               state_d = reject ? S_DONE : S_RD_A;
            end
         end
         S_RD_A: state_d = S_RD_B;
         S_RD_B: begin
            a_reg_d = rd_data;
            state_d = S_ACC;
         end
         S_ACC: begin
            acc_d   = mac_out;
            k_d     = k_q + IDX_W'(1);
            state_d = (k_q == kmax_q - IDX_W'(1)) ? S_WR : S_RD_A;
         end
         S_WR: begin
            acc_d = '0;
            k_d   = '0;
            if (j_q == c_q - IDX_W'(1)) begin
               j_d = '0;
               if (i_q == r_q - IDX_W'(1)) begin
                  state_d = S_DONE;
               end else begin
                  i_d     = i_q + IDX_W'(1);
                  state_d = S_RD_A;
               end
            end else begin
               j_d     = j_q + IDX_W'(1);
               state_d = S_RD_A;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // abort wins over every other transition
      if (calc_abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         acc_d   = '0;
         k_d     = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         start_q   <= 1'b0;
         op_q      <= 1'b0;
         err_q     <= 1'b0;
         r_q       <= '0;
         c_q       <= '0;
         kmax_q    <= '0;
         i_q       <= '0;
         j_q       <= '0;
         k_q       <= '0;
         a_reg_q   <= '0;
         acc_q     <= '0;
         res_row_q <= '0;
         res_col_q <= '0;
      end else begin
         state_q   <= state_d;
         start_q   <= start_d;
         op_q      <= op_d;
         err_q     <= err_d;
         r_q       <= r_d;
         c_q       <= c_d;
         kmax_q    <= kmax_d;
         i_q       <= i_d;
         j_q       <= j_d;
         k_q       <= k_d;
         a_reg_q   <= a_reg_d;
         acc_q     <= acc_d;
         res_row_q <= res_row_d;
         res_col_q <= res_col_d;
      end
   end

   always_comb begin
      rd_sel  = (state_q == S_RD_B);
      rd_addr = '0;
      if (state_q == S_RD_A) begin
         rd_addr = (op_q == OP_MUL) ? elem_addr(i_q, k_q) : elem_addr(i_q, j_q);
      end else if (state_q == S_RD_B) begin
         rd_addr = (op_q == OP_MUL) ? elem_addr(k_q, j_q) : elem_addr(i_q, j_q);
      end
      wr_en     = (state_q == S_WR);
      wr_addr   = wr_en ? elem_addr(i_q, j_q) : '0;
      wr_data   = wr_en ? acc_q : '0;
      res_row   = res_row_q;
      res_col   = res_col_q;
      busy      = (state_q != S_IDLE);
      calc_done = (state_q == S_DONE);
      calc_err  = (state_q == S_DONE) && err_q;
   end

endmodule

// File: tb/tb_matrix_calc_core.sv
// Directed-vector bench for matrix_calc_core with a registered memory model.
// Cycle numbers are counted from the cycle in which calc_start rises.
module tb_matrix_calc_core;
   import matrix_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              calc_start;
   logic              calc_abort;
   logic              op_code;
   logic [DIM_W-1:0]  matA_row, matA_col, matB_row, matB_col;
   logic              rd_sel;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [ACC_W-1:0]  wr_data;
   logic [DIM_W-1:0]  res_row, res_col;
   logic              busy, calc_done, calc_err;

   logic [DATA_W-1:0] mem_a [32];
   logic [DATA_W-1:0] mem_b [32];

   int nvec = 0;
   int nmis = 0;
   int done_cyc, ndone, nwr, busy_after;
   bit err_seen;
   int wa[$];
   int wd[$];

   matrix_calc_core dut (
      .clk        (clk),
      .rst        (rst),
      .calc_start (calc_start),
      .calc_abort (calc_abort),
      .op_code    (op_code),
      .matA_row   (matA_row),
      .matA_col   (matA_col),
      .matB_row   (matB_row),
      .matB_col   (matB_col),
      .rd_sel     (rd_sel),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .res_row    (res_row),
      .res_col    (res_col),
      .busy       (busy),
      .calc_done  (calc_done),
      .calc_err   (calc_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_data <= rd_sel ? mem_b[rd_addr] : mem_a[rd_addr];

   task automatic check(input string tag, input longint got, input longint exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic run_op(input bit op, input int ar, input int ac,
                         input int br, input int bc, input int limit,
                         input bit full, input int kill_at, input bit kill_rst);
      op_code  = op;
      matA_row = DIM_W'(ar);
      matA_col = DIM_W'(ac);
      matB_row = DIM_W'(br);
      matB_col = DIM_W'(bc);
      wa.delete();
      wd.delete();
      done_cyc   = -1;
      ndone      = 0;
      nwr        = 0;
      busy_after = -1;
      err_seen   = 1'b0;
      calc_start = 1'b1;
      for (int cyc = 0; cyc < limit; cyc++) begin
         if (cyc == kill_at) begin
            calc_start = 1'b0;
            if (kill_rst) rst = 1'b1;
            else calc_abort = 1'b1;
         end
         @(negedge clk);
         calc_abort = 1'b0;
         rst        = 1'b0;
         if (cyc == kill_at) busy_after = int'(busy);
         if (wr_en) begin
            nwr++;
            wa.push_back(int'(wr_addr));
            wd.push_back(int'(wr_data));
         end
         if (calc_done) begin
            ndone++;
            if (done_cyc < 0) done_cyc = cyc + 1;
            err_seen = calc_err;
         end
         if (!full && done_cyc >= 0) break;
      end
      calc_start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   function automatic int wr_a(input int i);
      return (i < wa.size()) ? wa[i] : -1;
   endfunction

   function automatic int wr_d(input int i);
      return (i < wd.size()) ? wd[i] : -1;
   endfunction

   int exp_add[4] = '{6, 8, 10, 12};
   int exp_mul[4] = '{58, 64, 139, 154};
   int exp_adr[4] = '{0, 1, 5, 6};

   initial begin
      rst        = 1'b1;
      calc_start = 1'b0;
      calc_abort = 1'b0;
      op_code    = 1'b0;
      matA_row   = '0;
      matA_col   = '0;
      matB_row   = '0;
      matB_col   = '0;
      for (int i = 0; i < 32; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", calc_done, 0);
      check("rst_err", calc_err, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_rd", {rd_sel, rd_addr}, 0);
      check("rst_wr_bus", {wr_addr, wr_data}, 0);
      check("rst_dims", {res_row, res_col}, 0);
      rst = 1'b0;
      @(negedge clk);

      // 2x2 add
      mem_a[0] = 1; mem_a[1] = 2; mem_a[5] = 3; mem_a[6] = 4;
      mem_b[0] = 5; mem_b[1] = 6; mem_b[5] = 7; mem_b[6] = 8;
      run_op(1'b0, 2, 2, 2, 2, 60, 1'b0, -1, 1'b0);
      check("add_done_cyc", done_cyc, 17);
      check("add_err", err_seen, 0);
      check("add_nwr", nwr, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("add_addr%0d", i), wr_a(i), exp_adr[i]);
         check($sformatf("add_data%0d", i), wr_d(i), exp_add[i]);
      end
      check("add_res_dims", {res_row, res_col}, {8'd2, 8'd2});

      // 2x3 * 3x2 mul
      mem_a[0] = 1; mem_a[1] = 2;  mem_a[2] = 3;
      mem_a[5] = 4; mem_a[6] = 5;  mem_a[7] = 6;
      mem_b[0] = 7; mem_b[1] = 8;
      mem_b[5] = 9; mem_b[6] = 10;
      mem_b[10] = 11; mem_b[11] = 12;
      run_op(1'b1, 2, 3, 3, 2, 100, 1'b0, -1, 1'b0);
      check("mul_done_cyc", done_cyc, 41);
      check("mul_err", err_seen, 0);
      check("mul_nwr", nwr, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("mul_addr%0d", i), wr_a(i), exp_adr[i]);
         check($sformatf("mul_data%0d", i), wr_d(i), exp_mul[i]);
      end

      // rejected: A 2x3, B 2x2
      run_op(1'b1, 2, 3, 2, 2, 20, 1'b0, -1, 1'b0);
      check("rej_done_cyc", done_cyc, 1);
      check("rej_err", err_seen, 1);
      check("rej_nwr", nwr, 0);

      // rejected: zero dimension on add
      run_op(1'b0, 0, 2, 0, 2, 20, 1'b0, -1, 1'b0);
      check("rej0_done_cyc", done_cyc, 1);
      check("rej0_err", err_seen, 1);

      // held start must not retrigger
      mem_a[0] = 1; mem_a[1] = 2; mem_a[5] = 3; mem_a[6] = 4;
      mem_b[0] = 5; mem_b[1] = 6; mem_b[5] = 7; mem_b[6] = 8;
      run_op(1'b0, 2, 2, 2, 2, 217, 1'b1, -1, 1'b0);
      check("hold_ndone", ndone, 1);
      check("hold_nwr", nwr, 4);
      run_op(1'b0, 2, 2, 2, 2, 60, 1'b0, -1, 1'b0);
      check("rerun_done_cyc", done_cyc, 17);
      check("rerun_data3", wr_d(3), 12);

      // 5x5 mul, all 255
      for (int i = 0; i < 32; i++) begin
         mem_a[i] = 8'd255;
         mem_b[i] = 8'd255;
      end
      run_op(1'b1, 5, 5, 5, 5, 500, 1'b0, -1, 1'b0);
      check("big_done_cyc", done_cyc, 401);
      check("big_nwr", nwr, 25);
      for (int i = 0; i < 25; i++) begin
         check($sformatf("big_addr%0d", i), wr_a(i), (i / 5) * 5 + (i % 5));
         check($sformatf("big_data%0d", i), wr_d(i), 325125);
      end

      // abort during cycle 10 of a 2x2 add
      mem_a[0] = 1; mem_a[1] = 2; mem_a[5] = 3; mem_a[6] = 4;
      mem_b[0] = 5; mem_b[1] = 6; mem_b[5] = 7; mem_b[6] = 8;
      run_op(1'b0, 2, 2, 2, 2, 40, 1'b1, 10, 1'b0);
      check("abort_nwr", nwr, 2);
      check("abort_ndone", ndone, 0);
      check("abort_busy", busy_after, 0);

      // reset during cycle 10 of a 2x2 add
      run_op(1'b0, 2, 2, 2, 2, 40, 1'b1, 10, 1'b1);
      check("rstmid_nwr", nwr, 2);
      check("rstmid_ndone", ndone, 0);
      check("rstmid_busy", busy_after, 0);
      check("rstmid_dims", {res_row, res_col}, 0);

      // core still usable afterwards
      run_op(1'b0, 2, 2, 2, 2, 60, 1'b0, -1, 1'b0);
      check("post_done_cyc", done_cyc, 17);
      check("post_data0", wr_d(0), 6);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
